// File: rtl/mem_pkg.sv
// Shared definitions for the MFA/MFC memory responder: op3 opcodes, FSM states,
// access sizes and small decode helpers.
package mem_pkg;

  localparam logic [5:0] OP_LD   = 6'b000000;
  localparam logic [5:0] OP_LDUB = 6'b000001;
  localparam logic [5:0] OP_LDUH = 6'b000010;
  localparam logic [5:0] OP_LDSB = 6'b001001;
  localparam logic [5:0] OP_LDSH = 6'b001010;
  localparam logic [5:0] OP_ST   = 6'b000100;
  localparam logic [5:0] OP_STB  = 6'b000101;
  localparam logic [5:0] OP_STH  = 6'b000110;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  typedef enum logic [1:0] {BYTE, HALF, WORD} size_e;

  typedef struct packed {
    logic  valid;
    logic  is_load;
    logic  sign_ext;
    size_e size;
  } op_info_t;

  function automatic op_info_t decode_op(input logic [5:0] op);
    op_info_t info;
    info = '{valid: 1'b1, is_load: 1'b1, sign_ext: 1'b0, size: WORD};
    case (op)
      OP_LD:   ;
      OP_LDUB: info.size = BYTE;
      OP_LDUH: info.size = HALF;
      OP_LDSB: begin info.size = BYTE; info.sign_ext = 1'b1; end
      OP_LDSH: begin info.size = HALF; info.sign_ext = 1'b1; end
      OP_ST:   info.is_load = 1'b0;
      OP_STB:  begin info.is_load = 1'b0; info.size = BYTE; end
      OP_STH:  begin info.is_load = 1'b0; info.size = HALF; end
      default: info.valid = 1'b0;
    endcase
    return info;
  endfunction

  // Bit i selects byte lane i of the aligned word; lane 0 is the lowest address (MSB).
  function automatic logic [3:0] lane_mask(input size_e size, input logic [1:0] off);
    case (size)
      BYTE:    return 4'b0001 << off;
      HALF:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic misaligned(input size_e size, input logic [1:0] off);
    return ((size == HALF) && off[0]) || ((size == WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_responder_256b_load_align_ext.sv
// Right-justifies the addressed byte/halfword of a fetched big-endian word and
// zero- or sign-extends it to 32 bits.
module load_align_ext
  import mem_pkg::*;
(
  input  logic [31:0] word_i,
  input  size_e       size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    case (off_i)
      2'd0:    byte_v = word_i[31:24];
      2'd1:    byte_v = word_i[23:16];
      2'd2:    byte_v = word_i[15:8];
      default: byte_v = word_i[7:0];
    endcase
    half_v = off_i[1] ? word_i[15:0] : word_i[31:16];
  end

  always_comb begin
    case (size_i)
      BYTE:    data_o = {{24{sign_i & byte_v[7]}}, byte_v};
      HALF:    data_o = {{16{sign_i & half_v[15]}}, half_v};
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/mem_responder_256b.sv
// Multi-cycle byte-addressed memory answering the MFA/MFC handshake with a
// programmable wait-state delay. Define RAM_BYTE_PARITY_EN for per-byte parity.
//
// state | meaning
// IDLE  | waiting for MFA; request latched on acceptance
// BUSY  | wait-state countdown, access performed when counter reaches 0
// DONE  | MFC held until MFA returns low
module mem_responder_256b
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              Clk,
  input  logic              Clr,
  input  logic              MFA,
  input  logic [5:0]        MOP,
  input  logic [ADDR_W-1:0] ADDR,
  input  logic [31:0]       DataIn,
  output logic [31:0]       DataOut,
  output logic              MFC,
  output logic              MAE,
  output logic              PERR
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [7:0] mem_q [DEPTH];

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        mop_q, mop_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d, dout_q, dout_d;
  logic              mfc_q, mfc_d, mae_q, mae_d, perr_q, perr_d;

  op_info_t          info;
  logic [1:0]        off;
  logic [3:0]        lanes, mem_we;
  logic [31:0]       rd_word, ld_data;
  logic [7:0]        wr_byte [4];
  logic [ADDR_W-1:0] lane_addr [4];
  logic              ld_perr;

  always_comb begin
    off   = addr_q[1:0];
    info  = decode_op(mop_q);
    lanes = lane_mask(info.size, off);
    for (int i = 0; i < 4; i++) begin
      lane_addr[i]          = {addr_q[ADDR_W-1:2], 2'(i)};
      rd_word[8*(3-i) +: 8] = mem_q[lane_addr[i]];
    end
    case (info.size)
      WORD: begin
        wr_byte[0] = din_q[31:24];
        wr_byte[1] = din_q[23:16];
        wr_byte[2] = din_q[15:8];
        wr_byte[3] = din_q[7:0];
      end
      HALF: begin
        wr_byte[0] = din_q[15:8];
        wr_byte[1] = din_q[7:0];
        wr_byte[2] = din_q[15:8];
        wr_byte[3] = din_q[7:0];
      end
      default: begin
        for (int i = 0; i < 4; i++) wr_byte[i] = din_q[7:0];
      end
    endcase
  end

  load_align_ext u_align (
    .word_i (rd_word),
    .size_i (info.size),
    .sign_i (info.sign_ext),
    .off_i  (off),
    .data_o (ld_data)
  );

`ifdef RAM_BYTE_PARITY_EN
  logic par_q [DEPTH];

  // Even parity: stored bit equals the XOR of the data byte.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) par_q[lane_addr[i]] <= ^wr_byte[i];
    end
  end

  always_comb begin
    ld_perr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (lanes[i] && ((^rd_word[8*(3-i) +: 8]) != par_q[lane_addr[i]])) ld_perr = 1'b1;
    end
  end
`else
  assign ld_perr = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mop_d   = mop_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    mae_d   = mae_q;
    perr_d  = perr_q;
    mem_we  = 4'b0000;
    case (state_q)
      IDLE: begin
        if (MFA) begin
          mop_d   = MOP;
          addr_d  = ADDR;
          din_d   = DataIn;
          cnt_d   = 4'(WAIT_STATES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (info.valid) begin
            if (misaligned(info.size, off)) begin
              mae_d = 1'b1;
            end else if (info.is_load) begin
              dout_d = ld_data;
              perr_d = ld_perr;
            end else begin
              mem_we = lanes;
            end
          end
          mfc_d   = 1'b1;
          state_d = DONE;
        end
      end
      default: begin
        if (!MFA) begin
          mfc_d   = 1'b0;
          mae_d   = 1'b0;
          perr_d  = 1'b0;
          state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Clr) begin
    if (!Clr) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mop_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      mfc_q   <= 1'b0;
      mae_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mop_q   <= mop_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      mae_q   <= mae_d;
      perr_q  <= perr_d;
    end
  end

  // Array contents survive reset; write enables are already gated by state_q.
  always_ff @(posedge Clk) begin
    for (int i = 0; i < 4; i++) begin
      if (mem_we[i]) mem_q[lane_addr[i]] <= wr_byte[i];
    end
  end

  assign DataOut = dout_q;
  assign MFC     = mfc_q;
  assign MAE     = mae_q;
  assign PERR    = perr_q;

endmodule

// File: tb/tb_mem_responder_256b.sv
// Directed bench for mem_responder_256b: table of request/expected-response
// records plus hand-written handshake, reset and parity sequences.
module tb_mem_responder_256b;
  import mem_pkg::*;

  logic        Clk, Clr, MFA;
  logic [5:0]  MOP;
  logic [7:0]  ADDR;
  logic [31:0] DataIn, DataOut;
  logic        MFC, MAE, PERR;

  mem_responder_256b #(.ADDR_W(8), .WAIT_STATES(2)) dut (
    .Clk(Clk), .Clr(Clr), .MFA(MFA), .MOP(MOP), .ADDR(ADDR), .DataIn(DataIn),
    .DataOut(DataOut), .MFC(MFC), .MAE(MAE), .PERR(PERR)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Issues a request and returns edges from acceptance to MFC (bounded).
  task automatic do_req(input logic [5:0] op, input logic [7:0] addr,
                        input logic [31:0] din, output int lat);
    int edges;
    @(negedge Clk);
    MOP = op; ADDR = addr; DataIn = din; MFA = 1'b1;
    edges = 0;
    do begin
      @(posedge Clk); #1;
      edges++;
      if (edges == 1) begin
        MOP = 6'h3F; ADDR = ~addr; DataIn = ~din;
      end
    end while (!MFC && edges < 40);
    lat = edges - 1;
  endtask

  task automatic finish_req();
    @(negedge Clk);
    MFA = 1'b0;
    @(posedge Clk); #1;
    check("mfc_drop", MFC, 32'd0);
  endtask

  typedef struct {
    logic [5:0]  op;
    logic [7:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_mae;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [5:0] op, input logic [7:0] addr, input logic [31:0] din,
                     input logic [31:0] exp_dout, input logic exp_mae);
    vec_t v;
    v.op = op; v.addr = addr; v.din = din; v.exp_dout = exp_dout; v.exp_mae = exp_mae;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, e;
    add(OP_ST,   8'h10, 32'hDEADBEEF, 32'h00000000, 1'b0);
    add(OP_LD,   8'h10, 32'h0,        32'hDEADBEEF, 1'b0);
    add(OP_LDSB, 8'h11, 32'h0,        32'hFFFFFFAD, 1'b0);
    add(OP_LDUB, 8'h11, 32'h0,        32'h000000AD, 1'b0);
    add(OP_STB,  8'h13, 32'h00000012, 32'h000000AD, 1'b0);
    add(OP_LD,   8'h10, 32'h0,        32'hDEADBE12, 1'b0);
    add(OP_LDSH, 8'h12, 32'h0,        32'hFFFFBE12, 1'b0);
    add(OP_LDUH, 8'h12, 32'h0,        32'h0000BE12, 1'b0);
    add(OP_LDUH, 8'h13, 32'h0,        32'h0000BE12, 1'b1);
    add(OP_LD,   8'h10, 32'h0,        32'hDEADBE12, 1'b0);
    add(OP_ST,   8'h20, 32'h11223344, 32'hDEADBE12, 1'b0);
    add(OP_ST,   8'h22, 32'hAABBCCDD, 32'hDEADBE12, 1'b1);
    add(OP_LD,   8'h20, 32'h0,        32'h11223344, 1'b0);
    add(OP_LDUB, 8'h23, 32'h0,        32'h00000044, 1'b0);
    add(OP_LDSH, 8'h20, 32'h0,        32'h00001122, 1'b0);
    add(OP_STH,  8'h22, 32'hFFFF8899, 32'h00001122, 1'b0);
    add(OP_LD,   8'h20, 32'h0,        32'h11228899, 1'b0);
    add(6'h3F,   8'h20, 32'h0,        32'h11228899, 1'b0);
    add(OP_LDSB, 8'h22, 32'h0,        32'hFFFFFF88, 1'b0);
    add(OP_ST,   8'hFC, 32'hCAFEF00D, 32'hFFFFFF88, 1'b0);
    add(OP_LD,   8'hFC, 32'h0,        32'hCAFEF00D, 1'b0);
    add(OP_LDSH, 8'hFE, 32'h0,        32'hFFFFF00D, 1'b0);
    add(OP_LD,   8'h21, 32'h0,        32'hFFFFF00D, 1'b1);
    add(OP_LDSB, 8'hFD, 32'h0,        32'hFFFFFFFE, 1'b0);
    add(OP_STH,  8'h23, 32'hFFFF0000, 32'hFFFFFFFE, 1'b1);
    add(OP_LD,   8'h20, 32'h0,        32'h11228899, 1'b0);

    Clr = 1'b0; MFA = 1'b0; MOP = '0; ADDR = '0; DataIn = '0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_mfc",  MFC,     32'd0);
    check("rst_mae",  MAE,     32'd0);
    check("rst_perr", PERR,    32'd0);
    check("rst_dout", DataOut, 32'd0);
    @(negedge Clk);
    Clr = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].op, vecs[i].addr, vecs[i].din, lat);
      check($sformatf("vec%0d_latency", i), lat, 32'd3);
      check($sformatf("vec%0d_dout", i), DataOut, vecs[i].exp_dout);
      check($sformatf("vec%0d_mae", i), MAE, {31'd0, vecs[i].exp_mae});
      check($sformatf("vec%0d_perr", i), PERR, 32'd0);
      finish_req();
    end

    // MFA held high after MFC: responder stays in DONE.
    do_req(OP_LD, 8'h10, 32'h0, lat);
    check("hold_latency", lat, 32'd3);
    for (int k = 0; k < 5; k++) begin
      @(posedge Clk); #1;
      check($sformatf("hold_mfc%0d", k), MFC, 32'd1);
      check($sformatf("hold_dout%0d", k), DataOut, 32'hDEADBE12);
    end
    finish_req();

    // MFA dropped during BUSY: access completes with a one-cycle MFC pulse.
    @(negedge Clk);
    MOP = OP_LDUB; ADDR = 8'h10; DataIn = '0; MFA = 1'b1;
    @(posedge Clk); #1;
    check("abort_mfc_busy", MFC, 32'd0);
    @(negedge Clk);
    MFA = 1'b0;
    e = 1;
    @(posedge Clk); #1;
    while (!MFC && e < 40) begin
      @(posedge Clk); #1;
      e++;
    end
    check("abort_latency", e, 32'd3);
    check("abort_dout", DataOut, 32'h000000DE);
    @(posedge Clk); #1;
    check("abort_pulse_end", MFC, 32'd0);

    // Reset mid-BUSY discards the pending store.
    do_req(OP_ST, 8'h30, 32'h55667788, lat);
    finish_req();
    @(negedge Clk);
    MOP = OP_ST; ADDR = 8'h30; DataIn = 32'h99999999; MFA = 1'b1;
    @(posedge Clk); #1;
    @(posedge Clk); #1;
    @(negedge Clk);
    Clr = 1'b0; MFA = 1'b0;
    #1;
    check("rstbusy_mfc", MFC, 32'd0);
    check("rstbusy_dout", DataOut, 32'd0);
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    Clr = 1'b1;
    do_req(OP_LD, 8'h30, 32'h0, lat);
    check("rstbusy_mem", DataOut, 32'h55667788);
    check("rstbusy_mfc_up", MFC, 32'd1);
    // Reset while DONE drops MFC at once.
    @(negedge Clk);
    Clr = 1'b0; MFA = 1'b0;
    #1;
    check("rstdone_mfc", MFC, 32'd0);
    check("rstdone_dout", DataOut, 32'd0);
    @(negedge Clk);
    Clr = 1'b1;

`ifdef RAM_BYTE_PARITY_EN
    dut.mem_q[8'h11] = dut.mem_q[8'h11] ^ 8'h01;
    do_req(OP_LDUB, 8'h11, 32'h0, lat);
    check("par_bad_perr", PERR, 32'd1);
    check("par_bad_dout", DataOut, 32'h000000AC);
    finish_req();
    check("par_perr_clear", PERR, 32'd0);
    do_req(OP_LDUB, 8'h10, 32'h0, lat);
    check("par_good_perr", PERR, 32'd0);
    finish_req();
`else
    do_req(OP_LDUB, 8'h11, 32'h0, lat);
    check("nopar_perr", PERR, 32'd0);
    check("nopar_dout", DataOut, 32'h000000AD);
    finish_req();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
